clic_gateway: RTL
=================

Name: clic_gateway

Overview:
- Per-source interrupt gateway between the raw interrupt lines and the CLIC register adapter.
- Normalises trigger polarity, detects edges, and holds edge pending state.
- Applies software set/clear of pending bits and clears pending on core acknowledge.
- Output `ip_o` drives the adapter's `ip_i`; trigger config and SW-written `ip` come back from the adapter outputs.

Parameters:
- N_SOURCE, 32, number of interrupt sources (≥1).
- SrcW, $clog2(N_SOURCE) (min 1), width of ack_id_i.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- intr_src_i  in  N_SOURCE  raw interrupt lines.
- le_i  in  N_SOURCE  trigger mode per source; 1 = edge, 0 = level (from attr_trig[0]).
- pol_i  in  N_SOURCE  polarity per source; 1 = active-low/falling (from attr_trig[1]).
- ip_sw_i  in  N_SOURCE  current ip register q; reflects a software write for one cycle.
- ack_valid_i  in  1  core has taken an interrupt this cycle.
- ack_id_i  in  SrcW  id of the taken interrupt.
- ip_o  out  N_SOURCE  pending bits to the adapter's ip_i.

Behaviour:
- State per source i:
  - ip_q: pending.
  - lvl_prev_q: previous normalised level.
  - pol_q: previous polarity.
  - optional sync flops.
- Reset: all state 0; ip_o = 0.
- Definitions:
  - s[i] = sampled line: intr_src_i[i], or the synchroniser output when the optional feature is enabled.
  - lvl[i] = s[i] XOR pol_i[i].
- Every cycle, regardless of mode: lvl_prev_q <= lvl; pol_q <= pol_i.
- Edge detect: edge[i] = le_i[i] & lvl[i] & ~lvl_prev_q[i] & (pol_i[i] == pol_q[i]).
  - A polarity change never produces an edge in the cycle it changes.
- Software write detect: sw_wr[i] = (ip_sw_i[i] != ip_q[i]), meaning q differs from the value driven last cycle.
- Ack clear: ack_clr[i] = ack_valid_i & (ack_id_i == i); ack_id_i ≥ N_SOURCE is ignored.
- Edge mode (le_i[i] = 1): ip_q[i] <= ((sw_wr[i] ? ip_sw_i[i] : ip_q[i]) & ~ack_clr[i]) | edge[i].
  - Priority, highest first: new edge > ack clear > software write > hold.
  - Edge + ack in the same cycle: pending stays 1; the new edge is not lost.
  - Edge + SW clear in the same cycle: pending stays 1.
- Level mode (le_i[i] = 0): ip_q[i] <= lvl[i].
  - Software writes and acks have no lasting effect; the bit follows the line one cycle later.
- Mode switch:
  - level→edge: ip_q retains its current value; an edge is detected only if lvl_prev_q = 0 in the switch cycle.
  - edge→level: ip_q follows lvl from the next cycle.
- Latency, line rise to ip_o = 1 (edge or level): 1 cycle without sync, 3 cycles with sync.
- ip_o = ip_q; registered, no combinational path from any input.
- After reset release, an edge-mode line already asserted (lvl = 1) becomes pending on the first clock, because lvl_prev_q resets to 0.
- Reset mid-operation clears all pending immediately (asynchronous).

Optional Feature:
- Macro: CLIC_GATEWAY_SYNC_EN.
- Defined:
  - Each intr_src_i bit passes through a 2-flop synchroniser (reset 0) before polarity/edge logic.
  - Source-to-ip_o latency is 3 cycles.
  - Pulses shorter than one clock may be missed.
- Undefined:
  - s = intr_src_i directly; caller guarantees synchronous inputs.
  - Latency is 1 cycle.

Test Plan:
- Edge, pol=0, N_SOURCE=8, src[3] 0→1 at cycle 10 and held: ip_o[3]=1 at cycle 11 and stays 1 while src stays high; ack id 3 at cycle 15 → ip_o[3]=0 at cycle 16 with no re-trigger.
- Edge, simultaneous ack_id=2 and new rising edge on src[2] in the same cycle → ip_o[2] remains 1 next cycle.
- Level, pol=1: src[5]=0 → ip_o[5]=1 one cycle later; src[5]=1 → ip_o[5]=0 one cycle later; ack_id=5 while line low → ip_o[5] stays 1.
- Software: edge mode, ip_sw_i[1] pulses 1 for one cycle while ip_q[1]=0 → ip_o[1]=1 held; ip_sw_i[1]=0 for one cycle while ip_q[1]=1 → ip_o[1]=0; same SW write in level mode with line low → ip_o[1] stays 0 after one cycle.
- Polarity flip on an idle edge source (pol 0→1, line low, so lvl 0→1) → no pending set; ack_id=9 with N_SOURCE=8 (SrcW=3 wraps to id 1 — bench uses N_SOURCE=10, id 12) → no bit cleared.
- With CLIC_GATEWAY_SYNC_EN: rising src[0] at cycle 10 → ip_o[0]=1 at cycle 13; rst_ni low at cycle 20 with several bits pending → ip_o=0 before the next clock edge.

Source files
------------

// File: rtl/clic_gateway.sv
// clic_gateway: per-source interrupt gateway (polarity, edge detect, pending, SW set/clear, ack clear); define CLIC_GATEWAY_SYNC_EN for 2-flop input synchronisers
module clic_gateway #(
  parameter int N_SOURCE = 32,
  parameter int SrcW     = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SOURCE-1:0] intr_src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] pol_i,
  input  logic [N_SOURCE-1:0] ip_sw_i,
  input  logic                ack_valid_i,
  input  logic [SrcW-1:0]     ack_id_i,
  output logic [N_SOURCE-1:0] ip_o
);
  logic [N_SOURCE-1:0] s;
  logic [N_SOURCE-1:0] lvl;
  logic [N_SOURCE-1:0] lvl_prev_q;
  logic [N_SOURCE-1:0] pol_q;
  logic [N_SOURCE-1:0] ip_q;
  logic [N_SOURCE-1:0] ip_d;
  logic [N_SOURCE-1:0] edge_det;
  logic [N_SOURCE-1:0] sw_wr;
  logic [N_SOURCE-1:0] sw_val;
  logic [N_SOURCE-1:0] ack_clr;
`ifdef CLIC_GATEWAY_SYNC_EN
  logic [N_SOURCE-1:0] sync1_q;
  logic [N_SOURCE-1:0] sync2_q;
  // two-flop synchroniser on every raw line
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= intr_src_i;
      sync2_q <= sync1_q;
    end
  assign s = sync2_q;
`else
  assign s = intr_src_i;
`endif
  // one-hot ack decode; ids beyond the last source match nothing
  always_comb
    for (int i = 0; i < N_SOURCE; i++) ack_clr[i] = ack_valid_i && (int'(ack_id_i) == i);
  // normalise polarity, detect edges, resolve pending with edge > ack > sw write > hold
  always_comb begin
    lvl      = s ^ pol_i;
    edge_det = le_i & lvl & ~lvl_prev_q & ~(pol_i ^ pol_q);
    sw_wr    = ip_sw_i ^ ip_q;
    sw_val   = (sw_wr & ip_sw_i) | (~sw_wr & ip_q);
    ip_d     = (le_i & ((sw_val & ~ack_clr) | edge_det)) | (~le_i & lvl);
  end
  // pending, previous level and previous polarity state
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ip_q       <= '0;
      lvl_prev_q <= '0;
      pol_q      <= '0;
    end else begin
      ip_q       <= ip_d;
      lvl_prev_q <= lvl;
      pol_q      <= pol_i;
    end
  assign ip_o = ip_q;
endmodule
